dmem_loader: RTL
================

# dmem_loader

Byte-stream loader that fills the data memory from a host link, for example a UART receiver, before or between CPU runs. It sits directly upstream of `dmem`. It parses a framed byte stream (start address, word count, payload) and packs each group of four bytes big-endian into a `DATA_W`-bit word. It then drives `dmem`'s `a`/`wd`/`we` write port one word per write cycle. The `busy` output lets the top level mux the `dmem` port away from the CPU and hold the CPU stalled while a frame is in flight.

## Interface
- `TIMEOUT`, default 1000000: max idle cycles between accepted bytes inside a frame before the frame is aborted; legal range 1 to 2^24-1.
- `DATA_W` comes from `def.h` and is 32. The block is written for exactly 4 bytes per word.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  loader can accept a byte; a byte transfers on a cycle with `in_valid && in_ready`.
- `a`  out  16  `dmem` word address.
- `wd`  out  `DATA_W`  `dmem` write data.
- `we`  out  1  `dmem` write enable, one cycle per word.
- `busy`  out  1  frame in progress; top level gives the `dmem` port to the loader while high.
- `done`  out  1  one-cycle pulse when a frame completes.
- `err`  out  1  one-cycle pulse when a frame is aborted by timeout.

## Operation
- Frame layout: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then 4×N payload bytes. Address and count are 16-bit big-endian. Each word is 4 bytes, MSB first.
- FSM states and transitions:
  - AH → AL → CH → CL: each advances on an accepted byte.
  - CL: if N==0, go to DONE; otherwise go to D with byte index 0.
  - D: each accepted byte shifts into the word register (`wd <= {wd[23:0], in_data}`). On the 4th byte go to WR.
  - WR: `we`=1 for one cycle at the current `a`. Then decrement the remaining count, increment `a`, and go to D, or to DONE when the count reaches 0.
  - DONE: `done`=1 for one cycle, then back to AH.
- `in_ready` = 1 in AH, AL, CH, CL and D. It is 0 in WR and DONE, and 0 while `rst` is high.
- `busy` = 1 from the cycle after ADDR_HI is accepted until the cycle DONE or the abort completes. It is 0 in AH.
- Address arithmetic is modulo 2^16: 16'hFFFF + 1 → 16'h0000, with no error flagged. The remaining-word counter is 16 bits; N up to 65535.
- Timeout counter:
  - Clears on every accepted byte and in AH.
  - Increments each cycle in AL, CH, CL and D when no byte is accepted.
  - On reaching `TIMEOUT`: `err` pulses for one cycle and the FSM returns to AH.
  - Any partially assembled word is discarded (no `we`). Words already written stay written.
- Bytes presented while `in_ready`=0 are not consumed. The source must hold them.
- `in_valid` without `in_ready` never advances state.

## Timing
- Reset (async assert, sync release):
  - State = AH; `a`=0, `wd`=0, count=0, timeout=0.
  - `we`=0, `busy`=0, `done`=0, `err`=0, `in_ready`=0 during reset.
- `a`/`wd` are registered and stable during the WR cycle. `dmem` captures on the rising edge that ends WR.
- Per-word throughput: 4 byte cycles + 1 WR cycle = 5 clocks minimum with a continuous stream.
- `done` is asserted the cycle after the last WR. For N==0 it is asserted the cycle after CL is accepted.
- `err` is asserted in the cycle where timeout equals `TIMEOUT`; the FSM is in AH on the next cycle.
- Reset mid-frame: immediate return to reset values with no write issued. If reset lands in WR, `we` deasserts asynchronously; whether the edge in that cycle wrote the word is don't-care.

## Test plan
- Stream 00 10 00 02 DE AD BE EF 01 02 03 04 continuously → writes `mem[16]`=32'hDEADBEEF and `mem[17]`=32'h01020304. `we` high exactly 2 cycles, 5 clocks apart. `done` pulses once, 1 cycle after the 2nd WR.
- Header 00 05 00 00 → no `we`. `done` pulses the cycle after CL; `busy` drops with it.
- Header FF FF 00 02 plus 8 bytes → writes at `a`=16'hFFFF then 16'h0000; no `err`.
- `TIMEOUT`=8: send 00 00 00 01 AA BB then stall → `err` pulse after 8 idle cycles, no `we`, FSM back in AH. A following valid frame loads correctly.
- Random `in_valid` gaps below `TIMEOUT` and `in_valid` held during WR → byte order preserved, no byte lost or duplicated. Compare against a scoreboard model of `dmem`.
- Assert `rst` during the 3rd payload byte of a 1-word frame → all outputs 0 immediately, no `we`. A fresh frame after release behaves normally.

Source files
------------

// File: rtl/dmem_loader_if.sv
// Host byte-stream link plus dmem write port and frame status for dmem_loader.
interface dmem_loader_if #(
  parameter int unsigned DATA_W = 32
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       a;
  logic [DATA_W-1:0] wd;
  logic              we;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output in_data, in_valid,
    input  in_ready, a, wd, we, busy, done, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, a, wd, we, busy, done, err
  );
endinterface

// File: rtl/dmem_loader.sv
// Parses ADDR(16) CNT(16) + 4*CNT payload bytes, packs big-endian words and
// writes them to dmem one per WR cycle; aborts a frame after TIMEOUT idle cycles.
module dmem_loader #(
  parameter int unsigned TIMEOUT = 1000000,
  parameter int unsigned DATA_W  = 32
) (
  input logic           clk,
  input logic           rst,
  dmem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_AH, S_AL, S_CH, S_CL, S_D, S_WR, S_DONE
  } state_t;

  localparam logic [23:0] TMO_LIM = 24'(TIMEOUT);

  state_t            state, state_nx;
  logic [15:0]       addr;
  logic [15:0]       cnt;
  logic [DATA_W-1:0] word;
  logic [1:0]        idx;
  logic [23:0]       tmo;

  logic in_frame, tmo_hit, ready, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_AH;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_frame = (state == S_AL) || (state == S_CH) || (state == S_CL) || (state == S_D);
    tmo_hit  = in_frame && (tmo == TMO_LIM);
    // Blocking the handshake on the abort cycle keeps a byte from being taken and then dropped.
    ready    = !rst && ((state == S_AH) || in_frame) && !tmo_hit;
    accept   = ready && bus.in_valid;
    if (tmo_hit) begin
      state_nx = S_AH;
    end else begin
      unique case (state)
        S_AH:   if (accept) state_nx = S_AL;
        S_AL:   if (accept) state_nx = S_CH;
        S_CH:   if (accept) state_nx = S_CL;
        S_CL:   if (accept) state_nx = ({cnt[15:8], bus.in_data} == 16'h0000) ? S_DONE : S_D;
        S_D:    if (accept && idx == 2'd3) state_nx = S_WR;
        S_WR:   state_nx = (cnt == 16'd1) ? S_DONE : S_D;
        S_DONE: state_nx = S_AH;
        default: state_nx = S_AH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr <= '0;
      cnt  <= '0;
      word <= '0;
      idx  <= '0;
      tmo  <= '0;
    end else begin
      if (accept) begin
        tmo <= '0;
        unique case (state)
          S_AH: addr[15:8] <= bus.in_data;
          S_AL: addr[7:0]  <= bus.in_data;
          S_CH: cnt[15:8]  <= bus.in_data;
          S_CL: begin
            cnt[7:0] <= bus.in_data;
            idx      <= '0;
          end
          S_D: begin
            word <= {word[DATA_W-9:0], bus.in_data};
            idx  <= idx + 2'd1;
          end
          default: ;
        endcase
      end else if (state == S_AH) begin
        tmo <= '0;
      end else if (in_frame && !tmo_hit) begin
        tmo <= tmo + 24'd1;
      end
      if (state == S_WR) begin
        cnt  <= cnt - 16'd1;
        addr <= addr + 16'd1;
      end
    end
  end

  assign bus.in_ready = ready;
  assign bus.a        = addr;
  assign bus.wd       = word;
  assign bus.we       = (state == S_WR);
  assign bus.busy     = in_frame || (state == S_WR);
  assign bus.done     = (state == S_DONE);
  assign bus.err      = tmo_hit;

endmodule
